// File: rtl/icache_bk_pkg.sv
// rtl/icache_bk_pkg.sv - shared geometry, state type and address helpers for the backup icache
package icache_bk_pkg;

  localparam int ADDR_W   = 32;
  localparam int S_INDEX  = 3;
  localparam int S_OFFSET = 5;
  localparam int S_TAG    = ADDR_W - S_INDEX - S_OFFSET;
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int LINE_W   = 8 * (2 ** S_OFFSET);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DONE
  } icache_state_t;

  // Tag field of a byte address.
  function automatic logic [S_TAG-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: S_TAG];
  endfunction

  // Set index field of a byte address.
  function automatic logic [S_INDEX-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[S_OFFSET +: S_INDEX];
  endfunction

  // Line-aligned version of a byte address, as presented to physical memory.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:S_OFFSET], {S_OFFSET{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_bk_tag_array.sv
// rtl/icache_bk_tag_array.sv - tag and valid storage, combinational lookup, single write port
module icache_bk_tag_array
  import icache_bk_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [S_INDEX-1:0] lookup_index,
  output logic [S_TAG-1:0]   lookup_tag,
  output logic               lookup_valid,
  input  logic               write,
  input  logic [S_INDEX-1:0] write_index,
  input  logic [S_TAG-1:0]   write_tag
);

  logic [S_TAG-1:0]    tags  [NUM_SETS];
  logic [NUM_SETS-1:0] valid;

  // Reset clears every set; otherwise a write installs a tag and marks the set valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      for (int i = 0; i < NUM_SETS; i++) begin
        tags[i] <= '0;
      end
    end else if (write) begin
      valid[write_index] <= 1'b1;
      tags[write_index]  <= write_tag;
    end
  end

  // Lookup is purely combinational so hits can complete in the request cycle.
  always_comb begin
    lookup_tag   = tags[lookup_index];
    lookup_valid = valid[lookup_index];
  end

endmodule

// File: rtl/icache_bk_ctrl.sv
// rtl/icache_bk_ctrl.sv - hit/miss controller and line writer for the backup icache data array
module icache_bk_ctrl
  import icache_bk_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   mem_address,
  input  logic                mem_read,
  output logic [31:0]         mem_rdata,
  output logic                mem_resp,
  output logic [ADDR_W-1:0]   pmem_address,
  output logic                pmem_read,
  input  logic [LINE_W-1:0]   pmem_rdata,
  input  logic                pmem_resp,
  output logic                da_web,
  output logic [S_INDEX-1:0]  da_index,
  output logic [LINE_W-1:0]   da_datain,
  input  logic [LINE_W-1:0]   da_dataout
);

  icache_state_t      state_q;
  icache_state_t      state_d;
  logic [ADDR_W-1:0]  miss_addr_q;
  logic               miss_latch;

  logic [S_TAG-1:0]   lookup_tag;
  logic               lookup_valid;
  logic               hit;
  logic               fill;
  logic [2:0]         word;
  logic [1:0]         addr_lsb_unused;

  // Byte-within-word bits never affect a 32-bit fetch.
  assign addr_lsb_unused = mem_address[1:0];
  assign word            = mem_address[4:2];

  icache_bk_tag_array u_tags (
    .clk          (clk),
    .rst          (rst),
    .lookup_index (addr_index(mem_address)),
    .lookup_tag   (lookup_tag),
    .lookup_valid (lookup_valid),
    .write        (fill),
    .write_index  (addr_index(miss_addr_q)),
    .write_tag    (addr_tag(miss_addr_q))
  );

  assign hit = mem_read & lookup_valid & (lookup_tag == addr_tag(mem_address));

  // The word mux always follows the live address; it is only meaningful with mem_resp.
  always_comb begin
    mem_rdata = da_dataout[{word, 5'd0} +: 32];
  end

  // State register and miss address capture; reset returns to IDLE from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_latch) begin
        miss_addr_q <= line_addr(mem_address);
      end
    end
  end

  // Next-state and output decode; a fill is suppressed when reset coincides with pmem_resp.
  always_comb begin
    state_d      = state_q;
    miss_latch   = 1'b0;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    fill         = 1'b0;
    da_web       = 1'b0;
    da_index     = addr_index(mem_address);
    da_datain    = pmem_rdata;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          mem_resp = 1'b1;
        end else if (mem_read) begin
          miss_latch = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = miss_addr_q;
        da_index     = addr_index(miss_addr_q);
        if (pmem_resp && !rst) begin
          fill    = 1'b1;
          da_web  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_icache_bk_ctrl.sv
// tb/tb_icache_bk_ctrl.sv - self-checking bench for icache_bk_ctrl with external data array model
module tb_icache_bk_ctrl;
  import icache_bk_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic [31:0]       mem_address;
  logic              mem_read;
  logic [31:0]       mem_rdata;
  logic              mem_resp;
  logic [31:0]       pmem_address;
  logic              pmem_read;
  logic [255:0]      pmem_rdata;
  logic              pmem_resp;
  logic              da_web;
  logic [2:0]        da_index;
  logic [255:0]      da_datain;
  logic [255:0]      da_dataout;

  int tests = 0;
  int fails = 0;
  bit mon_on = 1'b0;

  always #5 clk = ~clk;

  icache_bk_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .da_web       (da_web),
    .da_index     (da_index),
    .da_datain    (da_datain),
    .da_dataout   (da_dataout)
  );

  // External data array: combinational read, clocked write.
  logic [255:0] darr [8];
  assign da_dataout = darr[da_index];
  always @(posedge clk) begin
    if (da_web) darr[da_index] <= da_datain;
  end

  // Reference model: which line address each set holds.
  bit          m_valid [8];
  logic [23:0] m_tag   [8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] a);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = mem_word({a[31:5], 3'(w), 2'b00});
    return l;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return m_valid[a[7:5]] && (m_tag[a[7:5]] == a[31:8]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
    end
  endtask

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // One CPU fetch; on a miss, memory answers after resp_delay extra cycles.
  task automatic do_read(input logic [31:0] a, input bit exp_hit, input int resp_delay);
    logic [31:0] la;
    la = {a[31:5], 5'b0};
    @(negedge clk);
    mem_address = a;
    mem_read    = 1'b1;
    #1;
    if (exp_hit) begin
      chk("hit_resp", 256'(mem_resp), 256'(1));
      chk("hit_rdata", 256'(mem_rdata), 256'(mem_word(a)));
      chk("hit_no_pmem", 256'(pmem_read), 256'(0));
    end else begin
      chk("miss_no_resp", 256'(mem_resp), 256'(0));
      @(negedge clk); #1;
      chk("fetch_pmem_read", 256'(pmem_read), 256'(1));
      chk("fetch_pmem_addr", 256'(pmem_address), 256'(la));
      chk("fetch_da_index", 256'(da_index), 256'(a[7:5]));
      for (int i = 0; i < resp_delay; i++) begin
        @(negedge clk); #1;
        chk("wait_no_web", 256'(da_web), 256'(0));
        chk("wait_pmem_read", 256'(pmem_read), 256'(1));
      end
      @(negedge clk);
      pmem_resp  = 1'b1;
      pmem_rdata = mem_line(la);
      #1;
      chk("fill_web", 256'(da_web), 256'(1));
      chk("fill_index", 256'(da_index), 256'(a[7:5]));
      chk("fill_datain", da_datain, mem_line(la));
      @(negedge clk);
      pmem_resp  = 1'b0;
      pmem_rdata = {8{$urandom}};
      #1;
      chk("done_no_web", 256'(da_web), 256'(0));
      chk("done_no_resp", 256'(mem_resp), 256'(0));
      chk("done_no_pmem", 256'(pmem_read), 256'(0));
      @(negedge clk); #1;
      chk("miss_resp_lat2", 256'(mem_resp), 256'(1));
      chk("miss_rdata", 256'(mem_rdata), 256'(mem_word(a)));
      m_valid[a[7:5]] = 1'b1;
      m_tag[a[7:5]]   = a[31:8];
    end
    @(negedge clk);
    mem_read = 1'b0;
  endtask

  // Continuous invariants on the outputs, sampled mid low-phase.
  always @(negedge clk) begin
    #3;
    if (mon_on) begin
      chk("inv_resp_vs_pmem", 256'(mem_resp & pmem_read), 256'(0));
      chk("inv_web_in_fetch", 256'(da_web & ~pmem_read), 256'(0));
    end
  end

  typedef struct {
    logic [31:0] addr;
    bit          hit;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [31:0] a;
    vt[0] = '{32'h0000_0040, 1'b0};
    vt[1] = '{32'h0000_005C, 1'b1};
    vt[2] = '{32'h0000_1040, 1'b0};
    vt[3] = '{32'h0000_1048, 1'b1};
    vt[4] = '{32'h0000_0040, 1'b0};
    vt[5] = '{32'h0000_1044, 1'b0};
    vt[6] = '{32'h0000_0300, 1'b0};
    vt[7] = '{32'h0000_031F, 1'b1};

    for (int i = 0; i < 8; i++) darr[i] = '0;
    model_clear();
    rst         = 1'b1;
    mem_address = '0;
    mem_read    = 1'b0;
    pmem_rdata  = '0;
    pmem_resp   = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    chk("rst_mem_resp", 256'(mem_resp), 256'(0));
    chk("rst_pmem_read", 256'(pmem_read), 256'(0));
    chk("rst_da_web", 256'(da_web), 256'(0));
    chk("rst_pmem_addr", 256'(pmem_address), 256'(0));
    @(negedge clk);
    rst    = 1'b0;
    mon_on = 1'b1;

    // Directed table: cold miss, hit, tag conflicts.
    for (int i = 0; i < 8; i++) do_read(vt[i].addr, vt[i].hit, i % 3);

    // Address change and request drop during FETCH: fill completes on the latched line.
    @(negedge clk);
    mem_address = 32'h0000_0080;
    mem_read    = 1'b1;
    #1;
    chk("t4_miss", 256'(mem_resp), 256'(0));
    @(negedge clk);
    mem_address = 32'h0000_0100;
    mem_read    = 1'b0;
    #1;
    chk("t4_pmem_addr", 256'(pmem_address), 256'(32'h0000_0080));
    chk("t4_da_index", 256'(da_index), 256'(4));
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = mem_line(32'h0000_0080);
    #1;
    chk("t4_web", 256'(da_web), 256'(1));
    chk("t4_fill_index", 256'(da_index), 256'(4));
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("t4_done_no_resp", 256'(mem_resp), 256'(0));
    @(negedge clk); #1;
    chk("t4_idle_no_resp", 256'(mem_resp), 256'(0));
    chk("t4_idle_no_pmem", 256'(pmem_read), 256'(0));
    m_valid[4] = 1'b1;
    m_tag[4]   = 24'h0;
    do_read(32'h0000_0084, 1'b1, 0);

    // Reset coincident with pmem_resp: no array write, all sets invalidated.
    @(negedge clk);
    mem_address = 32'h0000_00A0;
    mem_read    = 1'b1;
    #1;
    chk("t5_miss", 256'(mem_resp), 256'(0));
    @(negedge clk); #1;
    chk("t5_fetch", 256'(pmem_read), 256'(1));
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = mem_line(32'h0000_00A0);
    rst        = 1'b1;
    #1;
    chk("t5_no_web", 256'(da_web), 256'(0));
    @(negedge clk);
    rst       = 1'b0;
    pmem_resp = 1'b0;
    mem_read  = 1'b0;
    #1;
    chk("t5_idle_pmem", 256'(pmem_read), 256'(0));
    chk("t5_idle_resp", 256'(mem_resp), 256'(0));
    model_clear();
    do_read(32'h0000_00A0, 1'b0, 1);
    do_read(32'h0000_0084, 1'b0, 0);

    // Random address stream against the model, with stray pmem_resp pulses while idle.
    for (int n = 0; n < 300; n++) begin
      a = {22'd0, 2'($urandom_range(0, 3)), 8'($urandom)};
      do_read(a, model_hit(a), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = {8{$urandom}};
        #1;
        chk("stray_resp_no_web", 256'(da_web), 256'(0));
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end

    @(negedge clk);
    mon_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
